wb_unit: RTL

Writeback unit for the RV32I core: the return path that pairs with the ALU operand selection. It accepts one retiring instruction per handshake from execute, selects the writeback source (ALU result, load data, pc+4, or immediate), aligns and sign/zero-extends load data returned by data memory, and drives a registered single write port into the register file. Loads stall the handshake until memory responds or a timeout expires.

---
 rtl/wb_unit_pkg.sv | 35 +++
 rtl/wb_unit_if.sv | 40 ++++
 rtl/wb_unit_load_align.sv | 50 +++++
 rtl/wb_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : core_pkg                                                 |
// | Purpose : Shared types and constants for the RV32I writeback path: |
// |           writeback source select, load funct3 encodings, and the  |
// |           writeback unit state type.                               |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Link address of an instruction; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : wb_unit_if                                             |
// | Purpose   : Bundles the execute handshake, data-memory response    |
// |             and register-file write port of the writeback unit.    |
// | Modports  : master - execute/memory/register-file side (drives the |
// |                      instruction and memory response)              |
// |             slave  - writeback unit                                |
// | Rev       : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
interface wb_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  wb_sel;
  logic        reg_wr;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pcreg;
  logic [31:0] imm;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;

  modport master (
    output ex_valid, wb_sel, reg_wr, rd, funct3, alu_result, pcreg, imm,
    output dmem_rvalid, dmem_rdata,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, load_err
  );

  modport slave (
    input  ex_valid, wb_sel, reg_wr, rd, funct3, alu_result, pcreg, imm,
    input  dmem_rvalid, dmem_rdata,
    output ex_ready, rf_we, rf_waddr, rf_wdata, load_err
  );
endinterface
`default_nettype wire

// File: rtl/wb_unit_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : load_align                                               |
// | Purpose : Combinational load data extraction. Picks the addressed  |
// |           byte/halfword out of the aligned memory word, sign- or   |
// |           zero-extends it, and flags misaligned or unknown loads.  |
// | Ports   : i_off     - byte offset within the word (addr[1:0])      |
// |           i_funct3  - load width/sign encoding                     |
// |           i_rdata   - raw aligned word from data memory            |
// |           o_data    - extended 32-bit load value                   |
// |           o_illegal - misaligned access or unsupported funct3      |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module load_align
  import core_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Lane selects: byte at 8*off, halfword at 16*off[1].
    w_byte    = i_rdata[{i_off, 3'b000} +: 8];
    w_half    = i_rdata[{i_off[1], 4'b0000} +: 16];
    o_data    = i_rdata;
    o_illegal = 1'b0;
    case (i_funct3)
      c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LBU: o_data = {24'h000000, w_byte};
      c_F3_LH: begin
        o_data    = {{16{w_half[15]}}, w_half};
        o_illegal = i_off[0];
      end
      c_F3_LHU: begin
        o_data    = {16'h0000, w_half};
        o_illegal = i_off[0];
      end
      c_F3_LW:  o_illegal = |i_off;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : wb_unit                                                  |
// | Purpose : RV32I writeback stage. Accepts one retiring instruction  |
// |           per handshake, selects ALU / load / pc+4 / immediate as  |
// |           the writeback value and drives a registered single       |
// |           register-file write port. Loads hold off the handshake   |
// |           until memory responds or a timeout expires.              |
// | Params  : TIMEOUT - max WAIT_MEM cycles before a load is abandoned |
// |                     (2..255)                                       |
// | Ports   : clk  - core clock                                        |
// |           rst  - synchronous active-high reset                     |
// |           bus  - wb_unit_if.slave: execute handshake + operands,   |
// |                  dmem response, rf write port, load_err pulse      |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module wb_unit
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  wb_unit_if.slave    bus
);

  localparam logic [7:0] c_TIMER_INIT = 8'(TIMEOUT);

  wb_state_e   r_state, w_state_nxt;
  logic [7:0]  r_timer, w_timer_nxt;

  // Load context captured at the handshake.
  logic [4:0]  r_rd;
  logic        r_reg_wr;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        w_capture;

  logic        r_rf_we, w_rf_we_nxt;
  logic [4:0]  r_rf_waddr, w_rf_waddr_nxt;
  logic [31:0] r_rf_wdata, w_rf_wdata_nxt;
  logic        r_load_err, w_load_err_nxt;

  logic        w_xfer;
  wb_sel_e     w_sel;
  logic [31:0] w_src;
  logic [1:0]  w_al_off;
  logic [2:0]  w_al_funct3;
  logic [31:0] w_al_data;
  logic        w_al_illegal;

  assign w_xfer = bus.ex_valid && (r_state == IDLE);
  assign w_sel  = wb_sel_e'(bus.wb_sel);

  // The aligner serves both phases: in IDLE it checks the incoming load
  // for legality; in WAIT_MEM it extracts from the captured context.
  assign w_al_off    = (r_state == IDLE) ? bus.alu_result[1:0] : r_off;
  assign w_al_funct3 = (r_state == IDLE) ? bus.funct3 : r_funct3;

  load_align u_load_align (
    .i_off     (w_al_off),
    .i_funct3  (w_al_funct3),
    .i_rdata   (bus.dmem_rdata),
    .o_data    (w_al_data),
    .o_illegal (w_al_illegal)
  );

  always_comb begin
    w_src = bus.alu_result;
    case (w_sel)
      WB_PC4:  w_src = pc_plus4(bus.pcreg);
      WB_IMM:  w_src = bus.imm;
      default: w_src = bus.alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= 8'd0;
      r_rd       <= 5'd0;
      r_reg_wr   <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_rf_we    <= w_rf_we_nxt;
      r_rf_waddr <= w_rf_waddr_nxt;
      r_rf_wdata <= w_rf_wdata_nxt;
      r_load_err <= w_load_err_nxt;
      if (w_capture) begin
        r_rd     <= bus.rd;
        r_reg_wr <= bus.reg_wr;
        r_funct3 <= bus.funct3;
        r_off    <= bus.alu_result[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_capture      = 1'b0;
    w_rf_we_nxt    = 1'b0;
    w_rf_waddr_nxt = r_rf_waddr;
    w_rf_wdata_nxt = r_rf_wdata;
    w_load_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_sel == WB_MEM) begin
            w_capture = 1'b1;
            if (w_al_illegal) begin
              w_load_err_nxt = 1'b1;
            end else begin
              w_state_nxt = WAIT_MEM;
              w_timer_nxt = c_TIMER_INIT;
            end
          end else begin
            w_rf_we_nxt    = bus.reg_wr && (bus.rd != 5'd0);
            w_rf_waddr_nxt = bus.rd;
            w_rf_wdata_nxt = w_src;
          end
        end
      end
      WAIT_MEM: begin
        // A response in the cycle the timer would expire still wins.
        if (bus.dmem_rvalid) begin
          w_rf_we_nxt    = r_reg_wr && (r_rd != 5'd0);
          w_rf_waddr_nxt = r_rd;
          w_rf_wdata_nxt = w_al_data;
          w_state_nxt    = IDLE;
          w_timer_nxt    = 8'd0;
        end else if (r_timer <= 8'd1) begin
          w_load_err_nxt = 1'b1;
          w_state_nxt    = IDLE;
          w_timer_nxt    = 8'd0;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ex_ready = (r_state == IDLE);
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.load_err = r_load_err;

endmodule
`default_nettype wire
